// File: rtl/mul_div_sequencer.sv
// Multi-cycle multiply/divide unit: shift-add multiply or restoring divide, one bit per clock.
// Results go to the HI/LO pair, which changes only on the edge that enters DONE.
module mul_div_sequencer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [5:0]        funct_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e state_q, state_d;

  logic [2*DATA_W-1:0] acc_q;     // multiply: {hi, multiplier}; divide: {rem, quot}
  logic [DATA_W-1:0]   opnd_q;    // multiplicand or divisor magnitude
  logic [CNT_W-1:0]    cnt_q;
  logic                is_div_q;
  logic                neg_q;
  logic                neg_rem_q;
  logic                dz_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  // Request decode
  logic              legal;
  logic              is_div_in;
  logic              is_signed_in;
  logic              accept;
  logic              div_zero_in;
  logic [DATA_W-1:0] mag1;
  logic [DATA_W-1:0] mag2;

  always_comb begin
    legal        = (funct_i == FnMult) || (funct_i == FnMultu) ||
                   (funct_i == FnDiv)  || (funct_i == FnDivu);
    is_div_in    = funct_i[1];
    is_signed_in = ~funct_i[0];
    accept       = (state_q == StIdle) && start_i && legal;
    div_zero_in  = is_div_in && (src2_i == '0);
    // MIN_INT negates to itself, which is the correct unsigned magnitude
    mag1         = (is_signed_in && src1_i[DATA_W-1]) ? -src1_i : src1_i;
    mag2         = (is_signed_in && src2_i[DATA_W-1]) ? -src2_i : src2_i;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = div_zero_in ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (cnt_q == LastCnt) begin
          state_d = StFix;
        end
      end
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o = (state_q != StIdle);
    done_o = (state_q == StDone);
    err_o  = (state_q == StDone) && dz_q;
    hi_o   = hi_q;
    lo_o   = lo_q;
  end

  // One iteration of either algorithm
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  logic [2*DATA_W-1:0] acc_step;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
    // Keep the bit shifted out of rem so divisors above 2**(DATA_W-1) work
    rem_sh   = acc_q[2*DATA_W-1:DATA_W-1];
    div_diff = rem_sh - {1'b0, opnd_q};
    div_ge   = rem_sh[DATA_W] | ~div_diff[DATA_W];
    acc_step = acc_q;
    if (is_div_q) begin
      if (div_ge) begin
        acc_step = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_step = {acc_q[2*DATA_W-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_step = {mul_sum, acc_q[DATA_W-1:1]};
      end else begin
        acc_step = {1'b0, acc_q[2*DATA_W-1:1]};
      end
    end
  end

  // Sign fix-up of the unsigned result
  logic [2*DATA_W-1:0] prod_neg;
  logic [DATA_W-1:0]   fix_hi;
  logic [DATA_W-1:0]   fix_lo;

  always_comb begin
    prod_neg = -acc_q;
    if (is_div_q) begin
      fix_lo = neg_q     ? -acc_q[DATA_W-1:0]          : acc_q[DATA_W-1:0];
      fix_hi = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W]   : acc_q[2*DATA_W-1:DATA_W];
    end else begin
      fix_lo = neg_q ? prod_neg[DATA_W-1:0]        : acc_q[DATA_W-1:0];
      fix_hi = neg_q ? prod_neg[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q     <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept) begin
        acc_q     <= {{DATA_W{1'b0}}, (is_div_in ? mag1 : mag2)};
        opnd_q    <= is_div_in ? mag2 : mag1;
        cnt_q     <= '0;
        is_div_q  <= is_div_in;
        neg_q     <= is_signed_in && (src1_i[DATA_W-1] ^ src2_i[DATA_W-1]);
        neg_rem_q <= is_signed_in && src1_i[DATA_W-1];
        dz_q      <= div_zero_in;
      end else if (state_q == StCalc) begin
        acc_q <= acc_step;
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == StFix) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Self-checking bench for mul_div_sequencer: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_mul_div_sequencer;

  localparam logic [5:0] FnMult  = 6'h18;
  localparam logic [5:0] FnMultu = 6'h19;
  localparam logic [5:0] FnDiv   = 6'h1A;
  localparam logic [5:0] FnDivu  = 6'h1B;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [5:0]  funct_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  mul_div_sequencer #(.DATA_W(32), .CNT_W(6)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .start_i (start_i),
    .funct_i (funct_i),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: plain 64-bit arithmetic; SV division truncates toward zero
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] phi, input logic [31:0] plo,
                                output logic [31:0] hi, output logic [31:0] lo,
                                output logic err);
    logic [63:0] p;
    longint sa, sb, q, r;
    err = 1'b0;
    hi  = phi;
    lo  = plo;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (f)
      FnMult: begin
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      FnMultu: begin
        p  = {32'h0, a} * {32'h0, b};
        hi = p[63:32];
        lo = p[31:0];
      end
      FnDiv: begin
        if (b == 0) err = 1'b1;
        else begin
          q  = sa / sb;
          r  = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      default: begin
        if (b == 0) err = 1'b1;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  // Drives one request and waits (bounded) for done_o; lat = edges after the accept edge
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic err_seen, output logic busy0,
                       output logic done_after, output logic busy_after, output logic hold_ok);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = hi_o;
    l0 = lo_o;
    start_i = 1'b1;
    funct_i = f;
    src1_i  = a;
    src2_i  = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    busy0   = busy_o;
    lat     = 0;
    hold_ok = 1'b1;
    while (!done_o && lat < 100) begin
      if (hi_o !== h0 || lo_o !== l0) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    err_seen = err_o;
    if (!done_o) lat = -1;
    @(posedge clk);
    #1;
    done_after = done_o;
    busy_after = busy_o;
  endtask

  task automatic test_reset();
    rst_i   = 1'b0;
    start_i = 1'b0;
    funct_i = '0;
    src1_i  = '0;
    src2_i  = '0;
    #3;
    checks++;
    if ({busy_o, done_o, err_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/err=%b want 000", {busy_o, done_o, err_o});
    end
    checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h/%h want 0/0", hi_o, lo_o);
    end
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
  endtask

  task automatic test_multu_max();
    int lat;
    logic e, b0, da, ba, hold;
    issue(FnMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, e, b0, da, ba, hold);
    checks++;
    if (lat !== 33) begin
      errors++;
      $display("FAIL multu_latency: got %0d want 33", lat);
    end
    checks++;
    if (hi_o !== 32'hFFFFFFFE || lo_o !== 32'h00000001) begin
      errors++;
      $display("FAIL multu_max: got %h/%h want fffffffe/00000001", hi_o, lo_o);
    end
    checks++;
    if (b0 !== 1'b1 || da !== 1'b0 || ba !== 1'b0 || e !== 1'b0) begin
      errors++;
      $display("FAIL multu_handshake: got busy0=%b done_next=%b busy_next=%b err=%b want 1000",
               b0, da, ba, e);
    end
    checks++;
    if (hold !== 1'b1) begin
      errors++;
      $display("FAIL multu_hold: got hold_ok=%b want 1", hold);
    end
    exp_hi = hi_o;
    exp_lo = lo_o;
  endtask

  task automatic test_signed_mul();
    logic [5:0]  fs [3] = '{FnMult, FnMult, FnMult};
    logic [31:0] as [3] = '{32'hFFFFFFFD, 32'h80000000, 32'h80000000};
    logic [31:0] bs [3] = '{32'd5, 32'h80000000, 32'hFFFFFFFF};
    for (int i = 0; i < 3; i++) begin
      int lat;
      logic e, b0, da, ba, hold, me;
      logic [31:0] wh, wl;
      issue(fs[i], as[i], bs[i], lat, e, b0, da, ba, hold);
      model(fs[i], as[i], bs[i], exp_hi, exp_lo, wh, wl, me);
      if (i == 0 && (wh !== 32'hFFFFFFFF || wl !== 32'hFFFFFFF1)) begin
        $display("Note: model disagrees with hand value for MULT -3*5");
      end
      checks++;
      if (hi_o !== wh || lo_o !== wl || lat !== 33) begin
        errors++;
        $display("FAIL mult_%0d: got %h/%h lat %0d want %h/%h lat 33", i, hi_o, lo_o, lat, wh, wl);
      end
      exp_hi = wh;
      exp_lo = wl;
    end
  endtask

  task automatic test_div();
    logic [5:0]  fs [5] = '{FnDiv, FnDivu, FnDiv, FnDivu, FnDiv};
    logic [31:0] as [5] = '{32'hFFFFFFF9, 32'd100, 32'h80000000, 32'hFFFFFFFF, 32'd7};
    logic [31:0] bs [5] = '{32'd2, 32'd7, 32'hFFFFFFFF, 32'h80000001, 32'hFFFFFFFE};
    logic [31:0] wh [5] = '{32'hFFFFFFFF, 32'd2, 32'd0, 32'h7FFFFFFE, 32'd1};
    logic [31:0] wl [5] = '{32'hFFFFFFFD, 32'd14, 32'h80000000, 32'd1, 32'hFFFFFFFD};
    for (int i = 0; i < 5; i++) begin
      int lat;
      logic e, b0, da, ba, hold;
      issue(fs[i], as[i], bs[i], lat, e, b0, da, ba, hold);
      checks++;
      if (hi_o !== wh[i] || lo_o !== wl[i] || lat !== 33 || e !== 1'b0) begin
        errors++;
        $display("FAIL div_%0d: got %h/%h lat %0d err %b want %h/%h lat 33 err 0",
                 i, hi_o, lo_o, lat, e, wh[i], wl[i]);
      end
      exp_hi = wh[i];
      exp_lo = wl[i];
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic e, b0, da, ba, hold;
    issue(FnDivu, 32'h451, 32'h20, lat, e, b0, da, ba, hold);
    checks++;
    if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
      errors++;
      $display("FAIL dz_setup: got %h/%h want 11/22", hi_o, lo_o);
    end
    issue(FnDivu, 32'd100, 32'd0, lat, e, b0, da, ba, hold);
    checks++;
    if (lat !== 0 || e !== 1'b1 || da !== 1'b0 || ba !== 1'b0) begin
      errors++;
      $display("FAIL dz_flags: got lat %0d err %b done_next %b busy_next %b want 0 1 0 0",
               lat, e, da, ba);
    end
    checks++;
    if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
      errors++;
      $display("FAIL dz_keep: got %h/%h want 11/22", hi_o, lo_o);
    end
    issue(FnDiv, 32'hFFFFFFF0, 32'd0, lat, e, b0, da, ba, hold);
    checks++;
    if (lat !== 0 || e !== 1'b1 || hi_o !== 32'h11 || lo_o !== 32'h22) begin
      errors++;
      $display("FAIL dz_signed: got lat %0d err %b %h/%h want 0 1 11/22", lat, e, hi_o, lo_o);
    end
    exp_hi = 32'h11;
    exp_lo = 32'h22;
  endtask

  task automatic test_overlap();
    int lat;
    logic busy_bad;
    @(negedge clk);
    start_i = 1'b1;
    funct_i = FnDivu;
    src1_i  = 32'd100;
    src2_i  = 32'd7;
    @(posedge clk);
    #1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start_i = 1'b1;
      funct_i = FnMultu;
      src1_i  = 32'h12345678;
      src2_i  = 32'h9ABCDEF0;
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    start_i = 1'b0;
    while (!done_o && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat !== 33 || hi_o !== 32'd2 || lo_o !== 32'd14) begin
      errors++;
      $display("FAIL overlap: got lat %0d %h/%h want 33 2/e", lat, hi_o, lo_o);
    end
    @(posedge clk);
    #1;
    busy_bad = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    funct_i = 6'h20;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (busy_o !== 1'b0 || done_o !== 1'b0) busy_bad = 1'b1;
    end
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (busy_bad !== 1'b0) begin
      errors++;
      $display("FAIL illegal_funct: got busy/done activity=%b want 0", busy_bad);
    end
    exp_hi = 32'd2;
    exp_lo = 32'd14;
  endtask

  task automatic test_abort();
    int lat;
    logic e, b0, da, ba, hold, seen_done;
    @(negedge clk);
    start_i = 1'b1;
    funct_i = FnMultu;
    src1_i  = 32'hFFFFFFFF;
    src2_i  = 32'd3;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: got busy %b done %b %h/%h want 0 0 0/0",
               busy_o, done_o, hi_o, lo_o);
    end
    seen_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done_o !== 1'b0) seen_done = 1'b1;
    end
    @(negedge clk);
    rst_i = 1'b1;
    issue(FnMultu, 32'd6, 32'd7, lat, e, b0, da, ba, hold);
    checks++;
    if (seen_done !== 1'b0 || lat !== 33 || hi_o !== 32'd0 || lo_o !== 32'd42) begin
      errors++;
      $display("FAIL abort_recover: got done_in_reset %b lat %0d %h/%h want 0 33 0/2a",
               seen_done, lat, hi_o, lo_o);
    end
    exp_hi = 32'd0;
    exp_lo = 32'd42;
  endtask

  task automatic test_random();
    logic [5:0] fs [4] = '{FnMult, FnMultu, FnDiv, FnDivu};
    for (int n = 0; n < 40; n++) begin
      int lat, wlat;
      logic e, b0, da, ba, hold, we;
      logic [31:0] a, b, wh, wl;
      logic [5:0] f;
      int mode;
      f    = fs[$urandom_range(0, 3)];
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 7);
      if (mode == 0) b = 32'd0;
      if (mode == 1) begin
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
      end
      if (mode == 2) b = $urandom_range(1, 20);
      if (mode == 3) a = a >> $urandom_range(0, 31);
      model(f, a, b, exp_hi, exp_lo, wh, wl, we);
      wlat = we ? 0 : 33;
      issue(f, a, b, lat, e, b0, da, ba, hold);
      checks++;
      if (hi_o !== wh || lo_o !== wl) begin
        errors++;
        $display("FAIL rand_%0d_result: f=%h a=%h b=%h got %h/%h want %h/%h",
                 n, f, a, b, hi_o, lo_o, wh, wl);
      end
      checks++;
      if (lat !== wlat || e !== we || ba !== 1'b0) begin
        errors++;
        $display("FAIL rand_%0d_timing: got lat %0d err %b busy_next %b want %0d %b 0",
                 n, lat, e, ba, wlat, we);
      end
      exp_hi = wh;
      exp_lo = wl;
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed_mul();
    test_div();
    test_div_zero();
    test_overlap();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
